// File: rtl/vec_strip_sequencer.sv
// vec_strip_sequencer
// Strip-mining controller for the 6-lane vector ALU. It accepts one vector
// operation of up to 48 elements and walks it through the lanes as
// consecutive 6-element chunks, one chunk per non-stalled cycle. It also
// AND-accumulates the per-chunk ALU flags into a single result.
module vec_strip_sequencer #(
  parameter int N      = 8,
  parameter int LANES  = 6,
  parameter int MAXLEN = 48
) (
  input  logic         clk,
  input  logic         reset,
  // issue-side handshake and operation fields
  input  logic         start,
  output logic         ready,
  input  logic [5:0]   op_len,
  input  logic [2:0]   op_alu,
  input  logic [1:0]   op_vsi,
  input  logic [N-1:0] op_imm,
  input  logic [3:0]   op_srcbi,
  input  logic         stall,
  // lane ALU control, held from accept to the next accept
  output logic [2:0]   ALUControlE,
  output logic [1:0]   VSIFlagE,
  output logic [N-1:0] ImmE,
  output logic [3:0]   SrcBiE,
  input  logic [1:0]   ALUFlagsE,
  // register-file / writeback side
  output logic         issue_valid,
  output logic [2:0]   chunk_idx,
  output logic [5:0]   lane_mask,
  output logic         done,
  output logic [1:0]   flags_out,
  output logic         busy
);

  localparam logic [5:0] LANES_W  = 6'(LANES);
  localparam logic [5:0] MAXLEN_W = 6'(MAXLEN);
  localparam logic [5:0] FULL_MASK = 6'b111111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DONE
  } state_e;

  // Lane mask for a chunk that still has 'rem' elements to cover; a chunk
  // with a full group (or more) of elements left lights all lanes.
  function automatic logic [5:0] mask_for(input logic [5:0] rem);
    if (rem >= LANES_W) begin
      return FULL_MASK;
    end
    return (6'd1 << rem) - 6'd1;
  endfunction

  state_e         state_q;
  logic           ready_q;
  logic           busy_q;
  logic           done_q;
  logic           issue_valid_q;
  logic [2:0]     chunk_idx_q;
  logic [5:0]     lane_mask_q;
  logic [1:0]     acc_q;
  logic [1:0]     flags_out_q;
  // Elements not yet retired, counting the chunk currently presented.
  logic [5:0]     rem_q;
  logic [2:0]     alu_q;
  logic [1:0]     vsi_q;
  logic [N-1:0]   imm_q;
  logic [3:0]     srcbi_q;

  logic [5:0]     len_clamped;
  logic           last_chunk;
  logic [5:0]     rem_d;
  logic [1:0]     acc_d;

  // Operand clamping, last-chunk detection and next remaining count.
  always_comb begin
    // NOTE: every signal assigned here gets a value on every path first, so
    // no latch is inferred even if a branch below is later edited away.
    len_clamped = op_len;
    rem_d       = '0;
    acc_d       = acc_q & ALUFlagsE;
    last_chunk  = (rem_q <= LANES_W);
    if (op_len > MAXLEN_W) begin
      len_clamped = MAXLEN_W;
    end
    // Only step down when another chunk follows, so the count never wraps.
    if (!last_chunk) begin
      rem_d = rem_q - LANES_W;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    if (reset) begin
      state_q       <= S_IDLE;
      ready_q       <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      issue_valid_q <= 1'b0;
      chunk_idx_q   <= '0;
      lane_mask_q   <= '0;
      acc_q         <= '0;
      flags_out_q   <= '0;
      rem_q         <= '0;
      alu_q         <= '0;
      vsi_q         <= '0;
      imm_q         <= '0;
      srcbi_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            alu_q       <= op_alu;
            vsi_q       <= op_vsi;
            imm_q       <= op_imm;
            srcbi_q     <= op_srcbi;
            acc_q       <= 2'b11;
            chunk_idx_q <= '0;
            flags_out_q <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
            if (op_vsi[0]) begin
              // Scalar op: a single one-lane chunk regardless of op_len.
              rem_q         <= 6'd1;
              lane_mask_q   <= 6'b000001;
              issue_valid_q <= 1'b1;
              state_q       <= S_ISSUE;
            end else if (len_clamped == '0) begin
              // Empty vector: nothing to issue, report cleared flags.
              rem_q         <= '0;
              lane_mask_q   <= '0;
              issue_valid_q <= 1'b0;
              done_q        <= 1'b1;
              state_q       <= S_DONE;
            end else begin
              rem_q         <= len_clamped;
              lane_mask_q   <= mask_for(len_clamped);
              issue_valid_q <= 1'b1;
              state_q       <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          // A stalled cycle holds the chunk and ignores the ALU flags.
          if (!stall) begin
            acc_q <= acc_d;
            if (last_chunk) begin
              flags_out_q   <= acc_d;
              issue_valid_q <= 1'b0;
              lane_mask_q   <= '0;
              rem_q         <= '0;
              done_q        <= 1'b1;
              state_q       <= S_DONE;
            end else begin
              chunk_idx_q <= chunk_idx_q + 3'd1;
              rem_q       <= rem_d;
              lane_mask_q <= mask_for(rem_d);
            end
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end

        default: begin
          state_q       <= S_IDLE;
          ready_q       <= 1'b1;
          busy_q        <= 1'b0;
          done_q        <= 1'b0;
          issue_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready       = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign issue_valid = issue_valid_q;
  assign chunk_idx   = chunk_idx_q;
  assign lane_mask   = lane_mask_q;
  assign flags_out   = flags_out_q;
  assign ALUControlE = alu_q;
  assign VSIFlagE    = vsi_q;
  assign ImmE        = imm_q;
  assign SrcBiE      = srcbi_q;

endmodule

// File: tb/tb_vec_strip_sequencer.sv
// Self-checking bench for vec_strip_sequencer: directed scenarios followed by
// randomized operations, all compared against a cycle-level reference model.
module tb_vec_strip_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       ready;
  logic [5:0] op_len;
  logic [2:0] op_alu;
  logic [1:0] op_vsi;
  logic [7:0] op_imm;
  logic [3:0] op_srcbi;
  logic       stall;
  logic [2:0] ALUControlE;
  logic [1:0] VSIFlagE;
  logic [7:0] ImmE;
  logic [3:0] SrcBiE;
  logic [1:0] ALUFlagsE;
  logic       issue_valid;
  logic [2:0] chunk_idx;
  logic [5:0] lane_mask;
  logic       done;
  logic [1:0] flags_out;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // Per-cycle stimulus plan for the busy period of one operation.
  logic       stall_plan [128];
  logic [1:0] flag_plan  [128];

  vec_strip_sequencer #(.N(8), .LANES(6), .MAXLEN(48)) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready),
    .op_len(op_len), .op_alu(op_alu), .op_vsi(op_vsi), .op_imm(op_imm),
    .op_srcbi(op_srcbi), .stall(stall), .ALUControlE(ALUControlE),
    .VSIFlagE(VSIFlagE), .ImmE(ImmE), .SrcBiE(SrcBiE), .ALUFlagsE(ALUFlagsE),
    .issue_valid(issue_valid), .chunk_idx(chunk_idx), .lane_mask(lane_mask),
    .done(done), .flags_out(flags_out), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_plan(input int stall_pct);
    for (int i = 0; i < 128; i++) begin
      stall_plan[i] = ($urandom_range(99) < stall_pct);
      flag_plan[i]  = 2'($urandom_range(3));
    end
  endtask

  // Called at a falling edge: outputs are settled from the previous rise.
  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_valid"}, 32'(issue_valid), 32'd0);
    check({tag, "_idx"}, 32'(chunk_idx), 32'd0);
    check({tag, "_mask"}, 32'(lane_mask), 32'd0);
    check({tag, "_flags"}, 32'(flags_out), 32'd0);
    check({tag, "_ctl"}, {ALUControlE, VSIFlagE, ImmE, SrcBiE}, 32'd0);
  endtask

  // Runs one operation from IDLE back to IDLE. The model derives the chunk
  // count by ceiling division and the tail mask from the remainder, then
  // walks the plan: a non-stalled issue cycle retires one chunk.
  task automatic run_op(input logic [5:0] len, input logic [1:0] vsi,
                        input logic [2:0] alu, input logic [7:0] imm,
                        input logic [3:0] srcbi, input bit poke_start);
    int eff_len, c, r, k, cyc, nst, exp_mask;
    logic [1:0] acc;
    eff_len = (int'(len) > 48) ? 48 : int'(len);
    c = vsi[0] ? 1 : (eff_len + 5) / 6;
    r = eff_len - 6 * (c - 1);
    check("idle_ready", 32'(ready), 32'd1);
    start = 1'b1; op_len = len; op_vsi = vsi; op_alu = alu;
    op_imm = imm; op_srcbi = srcbi;
    @(negedge clk);
    // Further start pulses with different fields must be ignored while busy.
    start = poke_start;
    op_alu = ~alu; op_vsi = ~vsi; op_imm = ~imm; op_srcbi = ~srcbi;
    op_len = 6'd5;
    acc = 2'b11; k = 0; cyc = 1; nst = 0;
    while (k < c && cyc < 120) begin
      if (vsi[0]) exp_mask = 1;
      else if (k == c - 1) exp_mask = (1 << r) - 1;
      else exp_mask = 63;
      check("iss_valid", 32'(issue_valid), 32'd1);
      check("iss_idx", 32'(chunk_idx), 32'(k));
      check("iss_mask", 32'(lane_mask), 32'(exp_mask));
      check("iss_busy", {ready, busy, done}, 32'b010);
      check("iss_alu", 32'(ALUControlE), 32'(alu));
      stall = stall_plan[cyc - 1];
      ALUFlagsE = flag_plan[cyc - 1];
      @(negedge clk);
      if (!stall_plan[cyc - 1]) begin
        acc = acc & flag_plan[cyc - 1];
        k++;
      end else begin
        nst++;
      end
      cyc++;
    end
    if (c == 0) acc = 2'b00;
    stall = 1'($urandom_range(1));
    check("done_pulse", {ready, busy, done, issue_valid}, 32'b0110);
    check("done_time", 32'(cyc), 32'(c + 1 + nst));
    check("done_flags", 32'(flags_out), 32'(acc));
    start = 1'b0;
    @(negedge clk);
    check("after_done", {ready, busy, done, issue_valid}, 32'b1000);
    check("held_flags", 32'(flags_out), 32'(acc));
    check("held_ctl", {ALUControlE, VSIFlagE, ImmE, SrcBiE}, {15'd0, alu, vsi, imm, srcbi});
    stall = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; ALUFlagsE = 2'b11;
    op_len = '0; op_alu = '0; op_vsi = '0; op_imm = '0; op_srcbi = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("rst");

    // len=12, flags always 11, no stall.
    fill_plan(0);
    for (int i = 0; i < 128; i++) flag_plan[i] = 2'b11;
    run_op(6'd12, 2'b00, 3'b110, 8'h5A, 4'd3, 1'b0);

    // len=13 with flags 11,01,11.
    fill_plan(0);
    flag_plan[0] = 2'b11; flag_plan[1] = 2'b01; flag_plan[2] = 2'b11;
    run_op(6'd13, 2'b00, 3'b010, 8'h11, 4'd1, 1'b0);

    // Scalar op ignores op_len.
    fill_plan(0);
    flag_plan[0] = 2'b10;
    run_op(6'd40, 2'b01, 3'b001, 8'hC3, 4'd9, 1'b0);

    // len=48, chunk 3 stalled for two cycles with flags forced to 00 there.
    fill_plan(0);
    for (int i = 0; i < 128; i++) flag_plan[i] = 2'b11;
    stall_plan[3] = 1'b1; stall_plan[4] = 1'b1;
    flag_plan[3] = 2'b00; flag_plan[4] = 2'b00;
    run_op(6'd48, 2'b00, 3'b100, 8'h80, 4'd15, 1'b0);

    // op_len=63 clamps to 48.
    fill_plan(0);
    run_op(6'd63, 2'b10, 3'b011, 8'h01, 4'd2, 1'b0);

    // Empty vector.
    fill_plan(0);
    run_op(6'd0, 2'b00, 3'b101, 8'h7F, 4'd4, 1'b1);

    // start while busy is ignored.
    fill_plan(20);
    run_op(6'd20, 2'b00, 3'b111, 8'hAA, 4'd6, 1'b1);

    // Reset during chunk 2 of a len=30 op.
    stall = 1'b0;
    start = 1'b1; op_len = 6'd30; op_vsi = 2'b00; op_alu = 3'b110;
    op_imm = 8'hEE; op_srcbi = 4'd7; ALUFlagsE = 2'b11;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_idx", 32'(chunk_idx), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("abort");
    @(negedge clk);
    check("abort_nodone", {ready, done}, 32'b10);

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      fill_plan(int'($urandom_range(40)));
      run_op(6'($urandom_range(63)), 2'($urandom_range(3)), 3'($urandom_range(7)),
             8'($urandom_range(255)), 4'($urandom_range(15)), 1'($urandom_range(1)));
      repeat ($urandom_range(2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vec_strip_sequencer.md
# vec_strip_sequencer

Strip-mining controller for the 6-lane vector ALU. It accepts one vector operation of up to 48 elements and sequences it through the 6 lanes as consecutive 6-element chunks, one chunk per cycle. It drives the lane ALU's control inputs and a chunk index and lane mask to the register-file and writeback side, and AND-accumulates the per-chunk ALU flags into a single result. It sits between the decode/issue stage and the lane ALU in the execute stage.

## Interface
Parameters:
- N, 8, element width (width of the immediate)
- LANES, 6, lanes per chunk (fixed at 6; other values unsupported)
- MAXLEN, 48, maximum elements per operation

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request to accept a new operation; honoured only while ready=1
- ready  out  1  sequencer idle, able to accept start
- op_len  in  6  element count; values above 48 are clamped to 48
- op_alu  in  3  ALU control code, latched at accept
- op_vsi  in  2  vector/scalar/immediate select, latched at accept
- op_imm  in  N  immediate, latched at accept
- op_srcbi  in  4  broadcast lane index for SrcB, latched at accept
- stall  in  1  downstream not accepting; holds the current chunk
- ALUControlE  out  3  latched op_alu
- VSIFlagE  out  2  latched op_vsi
- ImmE  out  N  latched op_imm
- SrcBiE  out  4  latched op_srcbi
- ALUFlagsE  in  2  aggregated flags from the lane ALU (combinational from the current chunk)
- issue_valid  out  1  current chunk is presented this cycle
- chunk_idx  out  3  index of the current 6-element group (0..7)
- lane_mask  out  6  active lanes of the current chunk (bit i = lane i)
- done  out  1  one-cycle completion pulse
- flags_out  out  2  accumulated flags; held from done until the next accepted start
- busy  out  1  operation in progress (ISSUE or DONE state)

## Operation
- States: IDLE, ISSUE, DONE. ready=1 only in IDLE. busy=1 in ISSUE and DONE.
- IDLE with start=1: latch the op fields, set acc=2'b11, chunk_idx=0, and compute the chunk count C.
  - Vector op (op_vsi[0]=0): C=ceil(len/6).
  - Scalar op (op_vsi[0]=1): C=1 and lane_mask=6'b000001; op_len is ignored.
- Vector op with len=0: go directly to DONE with flags_out=2'b00 and issue no chunks.
- Otherwise go to ISSUE.
- ISSUE:
  - issue_valid=1 every cycle.
  - lane_mask=6'b111111 except on the last chunk, where it is (1<<r)-1 with r=len-6*(C-1), r in 1..6.
  - On a cycle with stall=0: acc <= acc & ALUFlagsE. If this is the last chunk, go to DONE; otherwise chunk_idx increments.
  - On a cycle with stall=1: chunk_idx, lane_mask and acc are held, and ALUFlagsE is ignored.
- DONE:
  - done=1 for exactly one cycle, issue_valid=0, flags_out=acc, then go to IDLE.
  - The latched control outputs keep their values until the next accept.
- start while busy is ignored; no queueing.
- Arithmetic: chunk_idx is 3-bit and never exceeds 7 (48/6=8 chunks). The remaining-element count must not underflow.

## Timing
- Reset (synchronous) puts the block in IDLE. All outputs reset to:
  - ready=1
  - busy=0, done=0, issue_valid=0
  - chunk_idx=0, lane_mask=0
  - flags_out=2'b00
  - ALUControlE=0, VSIFlagE=0, ImmE=0, SrcBiE=0
- Reset mid-operation aborts immediately: no done pulse, and flags_out is cleared.
- Start accepted at edge t0, no stalls:
  - chunk k is presented in cycle t0+1+k, for k=0..C-1;
  - done is high in cycle t0+C+1;
  - ready returns in cycle t0+C+2.
- Each stalled cycle adds exactly one cycle to the timeline.
- Len=0 vector op: done in cycle t0+1, ready in cycle t0+2.
- Flags are sampled in the same cycle as the issue they belong to, since the ALU is combinational.
- Stall asserted in IDLE or DONE has no effect.

## Test plan
- Vector len=12, op_alu=3'b110, ALUFlagsE=2'b11 every cycle, no stall -> two issues with chunk_idx 0,1 and lane_mask 3F,3F; done in cycle t0+3; flags_out=2'b11.
- Vector len=13, ALUFlagsE=11,01,11 on successive issues -> three issues; last lane_mask=6'b000001; flags_out=2'b01.
- Scalar op (op_vsi=2'b01), op_len=40 -> exactly one issue with lane_mask=6'b000001 and chunk_idx=0; flags_out equals the sampled ALUFlagsE.
- Vector len=48 with stall=1 for 2 cycles on chunk 3 -> 8 issues, chunk_idx 0..7; chunk 3 held for 3 cycles; done in cycle t0+11; ALUFlagsE changes during the stall do not affect acc.
- op_len=63 -> clamped to 48: 8 chunks, final lane_mask=3F.
- Vector len=0 -> done in cycle t0+1 with flags_out=00 and no issue_valid.
- Reset asserted during chunk 2 of len=30 -> next cycle ready=1, busy=0, all outputs at reset values, no done.
- start pulsed while busy -> ignored; the latched ALUControlE is unchanged.
